uart_cmd_host: RTL and testbench

Host-side command initiator for the UART memory-access protocol. It encodes one read or write transaction into a command byte plus optional data bytes and pushes them into the transmit FIFO. For reads, it pops the returned bytes from the receive FIFO and presents them, tagged with their memory address, to the host logic. It is the initiating end of the link whose far end decodes command bytes and accesses the 16-entry memory.

---
 rtl/uart_cmd_host.sv | 202 ++++++++++++++++++++
 tb/tb_uart_cmd_host.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_host.sv
// uart_cmd_host: host-side initiator for the UART memory-access protocol.
// Encodes one read or write transaction as a command byte
// {count[2:0], base_addr[3:0], rw} plus optional write data bytes and pushes
// them into the transmit FIFO. For reads it pops the returned bytes from the
// receive FIFO and presents each one tagged with its memory address.
//
// Optional feature macro: CMD_HOST_TIMEOUT_EN. When defined, a read aborts
// after RSP_TIMEOUT consecutive empty-receive-FIFO cycles. When undefined,
// a read waits for its bytes indefinitely and timeout is always 0.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, rw, base_addr, count  transaction request (sampled in IDLE only)
//   wdata, wdata_valid, wdata_rd show-ahead host write buffer interface
//   tx_full, tx_wr, tx_data    transmit FIFO write side
//   rx_empty, rx_rd, rx_data   receive FIFO read side (data valid the cycle after rx_rd)
//   rdata, rdata_addr, rdata_valid  returned read byte and its address (1-cycle strobe)
//   busy, done, timeout        status: busy outside IDLE, done/timeout one-cycle pulses
module uart_cmd_host #(
  parameter int unsigned RSP_TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [3:0] base_addr,
  input  logic [2:0] count,
  input  logic [7:0] wdata,
  input  logic       wdata_valid,
  output logic       wdata_rd,
  input  logic       tx_full,
  output logic       tx_wr,
  output logic [7:0] tx_data,
  input  logic       rx_empty,
  output logic       rx_rd,
  input  logic [7:0] rx_data,
  output logic [7:0] rdata,
  output logic [3:0] rdata_addr,
  output logic       rdata_valid,
  output logic       busy,
  output logic       done,
  output logic       timeout
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_WDATA, S_RDATA, S_DONE} state_t;

  state_t     state_q, state_d;
  logic       rw_q, rw_d;
  logic [3:0] base_q, base_d;
  logic [2:0] count_q, count_d;
  logic [2:0] issued_q, issued_d;     // bytes written (WDATA) or popped (RDATA)
  logic [2:0] captured_q, captured_d; // read bytes registered onto rdata
  logic       rd_pend_q, rd_pend_d;   // rx_data is valid this cycle
  logic [7:0] rdata_q, rdata_d;
  logic [3:0] rdata_addr_q, rdata_addr_d;
  logic       rdata_valid_q, rdata_valid_d;
  logic       done_q, done_d;
  logic       timeout_q, timeout_d;

`ifdef CMD_HOST_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;
`else
  logic [15:0] unused_rsp_timeout;
  assign unused_rsp_timeout = 16'(RSP_TIMEOUT);
`endif

  // Flow-control strobes depend only on registered state and the FIFO flags,
  // so they are naturally 0 in IDLE and DONE.
  assign wdata_rd = (state_q == S_WDATA) && !tx_full && wdata_valid;
  assign tx_wr    = ((state_q == S_CMD) && !tx_full) || wdata_rd;
  assign tx_data  = (state_q == S_WDATA) ? wdata : {count_q, base_q, rw_q};
  assign rx_rd    = (state_q == S_RDATA) && !rx_empty && (issued_q != count_q);

  assign rdata       = rdata_q;
  assign rdata_addr  = rdata_addr_q;
  assign rdata_valid = rdata_valid_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign timeout     = timeout_q;

  always_comb begin
    // NOTE: every _d gets a default up front so no path through the case
    // leaves a variable unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    rw_d          = rw_q;
    base_d        = base_q;
    count_d       = count_q;
    issued_d      = issued_q;
    captured_d    = captured_q;
    rd_pend_d     = rx_rd;
    rdata_d       = rdata_q;
    rdata_addr_d  = rdata_addr_q;
    rdata_valid_d = rd_pend_q;
    timeout_d     = 1'b0;
`ifdef CMD_HOST_TIMEOUT_EN
    tmo_d         = tmo_q;
`endif

    // Capture runs regardless of state so a byte popped just before an
    // abort is still delivered.
    if (rd_pend_q) begin
      rdata_d      = rx_data;
      rdata_addr_d = base_q + {1'b0, captured_q};
      captured_d   = captured_q + 3'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_CMD;
          rw_d       = rw;
          base_d     = base_addr;
          count_d    = count;
          issued_d   = 3'd0;
          captured_d = 3'd0;
`ifdef CMD_HOST_TIMEOUT_EN
          tmo_d      = 16'd0;
`endif
        end
      end
      S_CMD: begin
        if (!tx_full) begin
          if (count_q == 3'd0) begin
            state_d = S_DONE;
          end else if (rw_q) begin
            state_d = S_RDATA;
`ifdef CMD_HOST_TIMEOUT_EN
            tmo_d   = 16'd0;
`endif
          end else begin
            state_d = S_WDATA;
          end
        end
      end
      S_WDATA: begin
        if (wdata_rd) begin
          issued_d = issued_q + 3'd1;
          if (issued_d == count_q) state_d = S_DONE;
        end
      end
      S_RDATA: begin
        if (rx_rd) issued_d = issued_q + 3'd1;
        if (rd_pend_q && (captured_d == count_q)) begin
          state_d = S_DONE;
        end
`ifdef CMD_HOST_TIMEOUT_EN
        else begin
          if (rx_rd)         tmo_d = 16'd0;
          else if (rx_empty) tmo_d = tmo_q + 16'd1;
          if (tmo_d == 16'(RSP_TIMEOUT)) begin
            state_d   = S_DONE;
            timeout_d = 1'b1;
          end
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    done_d = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of the others regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      rw_q          <= 1'b0;
      base_q        <= 4'd0;
      count_q       <= 3'd0;
      issued_q      <= 3'd0;
      captured_q    <= 3'd0;
      rd_pend_q     <= 1'b0;
      rdata_q       <= 8'd0;
      rdata_addr_q  <= 4'd0;
      rdata_valid_q <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
`ifdef CMD_HOST_TIMEOUT_EN
      tmo_q         <= 16'd0;
`endif
    end else begin
      state_q       <= state_d;
      rw_q          <= rw_d;
      base_q        <= base_d;
      count_q       <= count_d;
      issued_q      <= issued_d;
      captured_q    <= captured_d;
      rd_pend_q     <= rd_pend_d;
      rdata_q       <= rdata_d;
      rdata_addr_q  <= rdata_addr_d;
      rdata_valid_q <= rdata_valid_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
`ifdef CMD_HOST_TIMEOUT_EN
      tmo_q         <= tmo_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_cmd_host.sv
// Self-checking bench for uart_cmd_host. Transmit bytes and returned read
// bytes are predicted into scoreboard queues when a transaction is launched
// and popped as the DUT produces them. The transmit FIFO, receive FIFO and
// host write buffer are modelled with queues. Outputs are sampled on the
// falling edge; inputs change just after the rising edge.
module tb_uart_cmd_host;

`ifdef CMD_HOST_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 1023;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, rw;
  logic [3:0] base_addr;
  logic [2:0] count;
  logic [7:0] wdata;
  logic       wdata_valid, wdata_rd;
  logic       tx_full, tx_wr;
  logic [7:0] tx_data;
  logic       rx_empty, rx_rd;
  logic [7:0] rx_data;
  logic [7:0] rdata;
  logic [3:0] rdata_addr;
  logic       rdata_valid, busy, done, timeout;

  uart_cmd_host #(.RSP_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .base_addr(base_addr),
    .count(count), .wdata(wdata), .wdata_valid(wdata_valid), .wdata_rd(wdata_rd),
    .tx_full(tx_full), .tx_wr(tx_wr), .tx_data(tx_data), .rx_empty(rx_empty),
    .rx_rd(rx_rd), .rx_data(rx_data), .rdata(rdata), .rdata_addr(rdata_addr),
    .rdata_valid(rdata_valid), .busy(busy), .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t1    = 0;
  int done_cnt = 0;
  int done_rel = 0;
  int n_wrd    = 0;
  logic done_tmo = 1'b0;
  bit   s_rx_rd, s_wdata_rd, wstall;

  logic [7:0]  exp_tx[$];
  logic [11:0] exp_rd[$];
  logic [7:0]  rxq[$];
  logic [7:0]  wq[$];
  int tx_cycs[$];
  int rv_cycs[$];
  int rxrd_cycs[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic refresh();
    rx_empty    = (rxq.size() == 0);
    wdata_valid = (wq.size() != 0) && !wstall;
    wdata       = (wq.size() != 0) ? wq[0] : 8'h00;
  endtask

  task automatic monitor();
    int rel;
    logic [11:0] e;
    rel = cyc - t1 + 1;
    s_rx_rd    = rx_rd;
    s_wdata_rd = wdata_rd;
    if (tx_wr) begin
      check("tx_expected", 32'(exp_tx.size() != 0), 32'd1);
      if (exp_tx.size() != 0) check("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
      tx_cycs.push_back(rel);
    end
    if (tx_full) check("wr_while_full", 32'(tx_wr), 32'd0);
    if (!wdata_valid) check("pop_while_empty", 32'(wdata_rd), 32'd0);
    if (rx_rd) rxrd_cycs.push_back(rel);
    if (wdata_rd) n_wrd++;
    if (rdata_valid) begin
      check("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
      if (exp_rd.size() != 0) begin
        e = exp_rd.pop_front();
        check("rdata", 32'(rdata), 32'(e[7:0]));
        check("rdata_addr", 32'(rdata_addr), 32'(e[11:8]));
      end
      rv_cycs.push_back(rel);
    end
    if (done) begin
      done_cnt++;
      done_rel = rel;
      done_tmo = timeout;
    end
  endtask

  // One clock: monitor at the falling edge, then advance the FIFO and
  // write-buffer models just after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (rst_n) monitor();
    @(posedge clk);
    cyc++;
    #1;
    if (rst_n) begin
      if (s_rx_rd && rxq.size() != 0) rx_data = rxq.pop_front();
      if (s_wdata_rd && wq.size() != 0) void'(wq.pop_front());
    end
    s_rx_rd    = 1'b0;
    s_wdata_rd = 1'b0;
    refresh();
    #1;
  endtask

  task automatic do_start(input logic r, input logic [3:0] a, input logic [2:0] n);
    tx_cycs.delete(); rv_cycs.delete(); rxrd_cycs.delete();
    n_wrd = 0;
    rw = r; base_addr = a; count = n; start = 1'b1;
    tick();
    t1 = cyc;
    start = 1'b0;
    // Scramble the request inputs: the DUT must use its latched copy.
    rw = ~r; base_addr = ~a; count = ~n;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) tick();
    check({tag, "_done_seen"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_idle_after"}, 32'(busy), 32'd0);
`ifndef CMD_HOST_TIMEOUT_EN
    check({tag, "_no_timeout"}, 32'(done_tmo), 32'd0);
`endif
  endtask

  // Expect q to hold n consecutive cycle numbers starting at first.
  task automatic check_seq(input string tag, input int q[$], input int first, input int n);
    check({tag, "_len"}, 32'(q.size()), 32'(n));
    for (int i = 0; i < n; i++)
      if (i < q.size()) check($sformatf("%s_%0d", tag, i), 32'(q[i]), 32'(first + i));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_wr"}, 32'(tx_wr), 32'd0);
    check({tag, "_wdata_rd"}, 32'(wdata_rd), 32'd0);
    check({tag, "_rx_rd"}, 32'(rx_rd), 32'd0);
    check({tag, "_rdata_valid"}, 32'(rdata_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
    check({tag, "_rdata"}, 32'(rdata), 32'd0);
    check({tag, "_rdata_addr"}, 32'(rdata_addr), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b1; rw = 1'b0; base_addr = 4'h0; count = 3'd1;
    tx_full = 1'b0; rx_data = 8'h00; wstall = 1'b0;
    wq.push_back(8'hEE); rxq.push_back(8'hEE);
    refresh();
    #12;
    check_reset_outputs("por");
    start = 1'b0;
    wq.delete(); rxq.delete(); refresh();
    @(negedge clk); #1 rst_n = 1'b1;
    tick();

    // Write: base 3, count 2 -> 46 A5 5A in cycles 1..3, done in cycle 4.
    wq.push_back(8'hA5); wq.push_back(8'h5A); refresh();
    exp_tx.push_back(8'h46); exp_tx.push_back(8'hA5); exp_tx.push_back(8'h5A);
    do_start(1'b0, 4'h3, 3'd2);
    wait_done("wr2", 20);
    check_seq("wr2_tx", tx_cycs, 1, 3);
    check("wr2_done_cyc", 32'(done_rel), 32'd4);
    check("wr2_tx_left", 32'(exp_tx.size()), 32'd0);

    // Read: base E, count 3 -> 7D, bytes at E, F, 0; done with last rdata_valid.
    rxq.push_back(8'h11); rxq.push_back(8'h22); rxq.push_back(8'h33); refresh();
    exp_tx.push_back(8'h7D);
    exp_rd.push_back({4'hE, 8'h11}); exp_rd.push_back({4'hF, 8'h22}); exp_rd.push_back({4'h0, 8'h33});
    do_start(1'b1, 4'hE, 3'd3);
    wait_done("rd3", 20);
    check_seq("rd3_cmd", tx_cycs, 1, 1);
    check_seq("rd3_rxrd", rxrd_cycs, 2, 3);
    check_seq("rd3_rv", rv_cycs, 4, 3);
    check("rd3_done_cyc", 32'(done_rel), 32'd6);
    check("rd3_rd_left", 32'(exp_rd.size()), 32'd0);

    // Write with count 0: single command byte 0A, no data pop.
    wq.push_back(8'h99); refresh();
    exp_tx.push_back(8'h0A);
    do_start(1'b0, 4'h5, 3'd0);
    wait_done("wr0", 20);
    check_seq("wr0_tx", tx_cycs, 1, 1);
    check("wr0_done_cyc", 32'(done_rel), 32'd2);
    check("wr0_no_pop", 32'(n_wrd), 32'd0);
    wq.delete(); refresh();

    // Stall: tx_full high cycles 1..5 (start pulsed meanwhile), then
    // wdata_valid dropped for 3 cycles after the first data byte.
    tx_full = 1'b1;
    for (int i = 0; i < 4; i++) wq.push_back(8'hC1 + 8'(i));
    refresh();
    exp_tx.push_back(8'h8E);
    for (int i = 0; i < 4; i++) exp_tx.push_back(8'hC1 + 8'(i));
    do_start(1'b0, 4'h7, 3'd4);
    tick();
    rw = 1'b1; base_addr = 4'hF; count = 3'd7; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    tx_full = 1'b0;
    for (int i = 0; i < 20 && tx_cycs.size() < 2; i++) tick();
    check("stall_reach_data", 32'(tx_cycs.size()), 32'd2);
    wstall = 1'b1; refresh();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_no_wr", 32'(tx_cycs.size()), 32'd2);
    end
    wstall = 1'b0; refresh();
    wait_done("stall", 30);
    check("stall_cmd_cyc", 32'(tx_cycs.size() != 0 ? tx_cycs[0] : 0), 32'd6);
    check("stall_done_cyc", 32'(done_rel), 32'd14);
    check("stall_pops", 32'(n_wrd), 32'd4);
    check("stall_tx_left", 32'(exp_tx.size()), 32'd0);
    check("stall_wq_left", 32'(wq.size()), 32'd0);

`ifdef CMD_HOST_TIMEOUT_EN
    // Timeout: read count 2, only one byte ever arrives.
    rxq.push_back(8'h5C); refresh();
    exp_tx.push_back(8'h45);
    exp_rd.push_back({4'h2, 8'h5C});
    do_start(1'b1, 4'h2, 3'd2);
    wait_done("tmo", 40);
    check_seq("tmo_rxrd", rxrd_cycs, 2, 1);
    check_seq("tmo_rv", rv_cycs, 4, 1);
    check("tmo_done_cyc", 32'(done_rel), 32'd11);
    check("tmo_flag", 32'(done_tmo), 32'd1);
    check("tmo_rd_left", 32'(exp_rd.size()), 32'd0);
`endif

    // Reset mid-WDATA after 1 of 4 bytes: outputs drop at once.
    for (int i = 0; i < 4; i++) wq.push_back(8'hD1 + 8'(i));
    refresh();
    exp_tx.push_back(8'h92); exp_tx.push_back(8'hD1);
    do_start(1'b0, 4'h9, 3'd4);
    for (int i = 0; i < 20 && tx_cycs.size() < 2; i++) tick();
    check("mid_reach_data", 32'(tx_cycs.size()), 32'd2);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("mid");
    wq.delete(); exp_tx.delete(); s_rx_rd = 1'b0; s_wdata_rd = 1'b0; refresh();
    @(negedge clk); #1 rst_n = 1'b1;
    tick();

    // After reset: write base 0, count 1 -> command 20.
    wq.push_back(8'hC3); refresh();
    exp_tx.push_back(8'h20); exp_tx.push_back(8'hC3);
    do_start(1'b0, 4'h0, 3'd1);
    wait_done("post", 20);
    check_seq("post_tx", tx_cycs, 1, 2);
    check("post_tx_left", 32'(exp_tx.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
